// File: rtl/difftest_sched.sv
// Difftest event scheduler: serialises retire/exception events from writeback into the
// single trace recorder port, buffering bursts in a small FIFO and draining on halt.
module difftest_sched #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_inst,
  input  logic        wb_inv,
  input  logic        wb_ex,
  input  logic        wb_ertn,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_ex_pc,
  output logic        wb_ready,
  input  logic        halt_req,
  input  logic        dt_ready,
  output logic        dt_valid,
  output logic [31:0] dt_pc,
  output logic [31:0] dt_inst,
  output logic        dt_inv,
  output logic        dt_ex,
  output logic        dt_ertn,
  output logic [5:0]  dt_ecode,
  output logic [8:0]  dt_esubcode,
  output logic [31:0] dt_ex_pc,
  output logic        halt_done
);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  // data carries the instruction word for commits, {ecode, esubcode} for exc/ertn
  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] pc;
    logic [31:0] data;
    logic        inv;
  } entry_t;

  localparam logic [1:0] KindNone   = 2'd0;
  localparam logic [1:0] KindCommit = 2'd1;
  localparam logic [1:0] KindExc    = 2'd2;
  localparam logic [1:0] KindErtn   = 2'd3;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [AW:0]   count_q, count_d;
  entry_t        out_q, out_d;
  state_e        state_q, state_d;

  entry_t     in0, in1, wr0;
  logic       has_commit, has_event;
  logic [1:0] n_in, n_wr;
  logic       out_empty, load, fifo_empty, pop, bypass;

  // Two free slots are needed since one cycle can carry a commit plus an exception.
  assign wb_ready = ~reset & (state_q == StRun) & (count_q <= (AW+1)'(DEPTH - 2));

  // Build incoming entries in program order and decide push/pop/bypass for this cycle.
  always_comb begin
    has_commit = wb_ready & wb_valid;
    has_event  = wb_ready & (wb_ex | wb_ertn);
    n_in       = {1'b0, has_commit} + {1'b0, has_event};

    in1.kind = wb_ex ? KindExc : KindErtn;
    in1.pc   = wb_ex_pc;
    in1.data = {17'b0, wb_ecode, wb_esubcode};
    in1.inv  = 1'b0;

    in0 = in1;
    if (has_commit) begin
      in0.kind = KindCommit;
      in0.pc   = wb_pc;
      in0.data = wb_inst;
      in0.inv  = wb_inv;
    end

    out_empty  = (out_q.kind == KindNone);
    load       = out_empty | dt_ready;
    fifo_empty = (count_q == '0);
    pop        = load & ~fifo_empty;
    // With an empty FIFO the oldest incoming event skips storage, giving one-cycle latency.
    bypass     = load & fifo_empty & (n_in != 2'd0);

    wr0  = bypass ? in1 : in0;
    n_wr = bypass ? (n_in - 2'd1) : n_in;

    out_d = out_q;
    if (pop) begin
      out_d = mem_q[rptr_q];
    end else if (bypass) begin
      out_d = in0;
    end else if (load) begin
      out_d = '0;
    end

    rptr_d  = rptr_q + AW'(pop);
    wptr_d  = wptr_q + AW'(n_wr);
    count_d = count_q + (AW+1)'(n_wr) - (AW+1)'(pop);
  end

  // Run/drain/done sequencing; halt requests outside RUN are ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (halt_req) state_d = StDrain;
      StDrain: if (fifo_empty && out_empty) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StRun;
    endcase
  end

  // Pointer, count, output stage and FSM registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      out_q   <= '0;
      state_q <= StRun;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      out_q   <= out_d;
      state_q <= state_d;
    end
  end

  // FIFO storage; contents are logically discarded by the pointer reset.
  always_ff @(posedge clock) begin
    if (!reset && n_wr != 2'd0) mem_q[wptr_q] <= wr0;
    if (!reset && n_wr == 2'd2) mem_q[wptr_q + AW'(1)] <= in1;
  end

  assign dt_valid    = (out_q.kind == KindCommit);
  assign dt_ex       = (out_q.kind == KindExc);
  assign dt_ertn     = (out_q.kind == KindErtn);
  assign dt_pc       = dt_valid ? out_q.pc : 32'd0;
  assign dt_inst     = dt_valid ? out_q.data : 32'd0;
  assign dt_inv      = dt_valid & out_q.inv;
  assign dt_ex_pc    = (dt_ex | dt_ertn) ? out_q.pc : 32'd0;
  assign dt_ecode    = (dt_ex | dt_ertn) ? out_q.data[14:9] : 6'd0;
  assign dt_esubcode = (dt_ex | dt_ertn) ? out_q.data[8:0] : 9'd0;
  assign halt_done   = (state_q == StDone);

endmodule

// File: tb/tb_difftest_sched.sv
// Directed bench for difftest_sched: ordering, backpressure, halt drain and reset.
module tb_difftest_sched;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_valid, wb_inv, wb_ex, wb_ertn, halt_req, dt_ready;
  logic [31:0] wb_pc, wb_inst, wb_ex_pc;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic        wb_ready, dt_valid, dt_inv, dt_ex, dt_ertn, halt_done;
  logic [31:0] dt_pc, dt_inst, dt_ex_pc;
  logic [5:0]  dt_ecode;
  logic [8:0]  dt_esubcode;

  int checks = 0;
  int errors = 0;

  difftest_sched #(.DEPTH(8), .AW(3)) dut (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_inv(wb_inv),
    .wb_ex(wb_ex), .wb_ertn(wb_ertn), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_ex_pc(wb_ex_pc), .wb_ready(wb_ready), .halt_req(halt_req), .dt_ready(dt_ready),
    .dt_valid(dt_valid), .dt_pc(dt_pc), .dt_inst(dt_inst), .dt_inv(dt_inv),
    .dt_ex(dt_ex), .dt_ertn(dt_ertn), .dt_ecode(dt_ecode), .dt_esubcode(dt_esubcode),
    .dt_ex_pc(dt_ex_pc), .halt_done(halt_done)
  );

  always #5 clock = ~clock;

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 0; wb_pc = 0; wb_inst = 0; wb_inv = 0; wb_ex = 0; wb_ertn = 0;
    wb_ecode = 0; wb_esubcode = 0; wb_ex_pc = 0; halt_req = 0;
  endtask

  task automatic commit(input logic [31:0] pc);
    idle_inputs();
    wb_valid = 1; wb_pc = pc; wb_inst = pc ^ 32'hA5A5_0000;
  endtask

  task automatic do_reset();
    idle_inputs();
    dt_ready = 1;
    reset = 1;
    tick();
    tick();
    reset = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({dt_valid, dt_ex, dt_ertn, dt_inv, halt_done} !== 5'b0 || dt_pc !== 0 ||
        dt_ex_pc !== 0 || dt_ecode !== 0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b ex=%b ertn=%b hd=%b pc=%h, want all 0",
               dt_valid, dt_ex, dt_ertn, halt_done, dt_pc);
    end
    checks++;
    if (wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_wb_ready: got %b want 1", wb_ready);
    end
  endtask

  task automatic test_commits();
    logic [31:0] pcs [3];
    pcs[0] = 32'h8000_0000; pcs[1] = 32'h8000_0004; pcs[2] = 32'h8000_0008;
    for (int i = 0; i < 3; i++) begin
      commit(pcs[i]);
      tick();
      checks++;
      if (dt_valid !== 1'b1 || dt_pc !== pcs[i] || dt_inst !== (pcs[i] ^ 32'hA5A5_0000)) begin
        errors++;
        $display("FAIL commit_%0d: got v=%b pc=%h inst=%h want v=1 pc=%h", i, dt_valid, dt_pc,
                 dt_inst, pcs[i]);
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (dt_valid !== 1'b0 || dt_pc !== 0) begin
      errors++;
      $display("FAIL commit_idle: got v=%b pc=%h want 0/0", dt_valid, dt_pc);
    end
  endtask

  task automatic test_commit_exc();
    commit(32'h10);
    wb_ex = 1; wb_ecode = 6'h0B; wb_esubcode = 9'h0; wb_ex_pc = 32'h10;
    tick();
    idle_inputs();
    checks++;
    if (dt_valid !== 1'b1 || dt_pc !== 32'h10 || dt_ex !== 1'b0) begin
      errors++;
      $display("FAIL cex_commit: got v=%b ex=%b pc=%h want v=1 ex=0 pc=10", dt_valid, dt_ex,
               dt_pc);
    end
    tick();
    checks++;
    if (dt_ex !== 1'b1 || dt_valid !== 1'b0 || dt_ecode !== 6'h0B || dt_ex_pc !== 32'h10 ||
        dt_pc !== 0) begin
      errors++;
      $display("FAIL cex_exc: got ex=%b v=%b ecode=%h ex_pc=%h pc=%h want 1 0 0b 10 0", dt_ex,
               dt_valid, dt_ecode, dt_ex_pc, dt_pc);
    end
    tick();
    checks++;
    if ({dt_valid, dt_ex, dt_ertn} !== 3'b000) begin
      errors++;
      $display("FAIL cex_idle: got %b want 000", {dt_valid, dt_ex, dt_ertn});
    end
  endtask

  task automatic test_backpressure();
    dt_ready = 0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wb_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_ready_%0d: got %b want 1", i, wb_ready);
      end
      commit(32'h100 + 32'(4 * i));
      tick();
    end
    idle_inputs();
    checks++;
    if (wb_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_full: got %b want 0 at count 7", wb_ready);
    end
    repeat (3) tick();
    checks++;
    if (dt_valid !== 1'b1 || dt_pc !== 32'h100) begin
      errors++;
      $display("FAIL bp_hold: got v=%b pc=%h want v=1 pc=100", dt_valid, dt_pc);
    end
    dt_ready = 1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dt_valid !== 1'b1 || dt_pc !== 32'h100 + 32'(4 * i)) begin
        errors++;
        $display("FAIL bp_drain_%0d: got v=%b pc=%h want v=1 pc=%h", i, dt_valid, dt_pc,
                 32'h100 + 32'(4 * i));
      end
      tick();
    end
    checks++;
    if (dt_valid !== 1'b0 || wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_empty: got v=%b ready=%b want 0 1", dt_valid, wb_ready);
    end
  endtask

  task automatic test_ex_ertn();
    idle_inputs();
    wb_ex = 1; wb_ertn = 1; wb_ecode = 6'h08; wb_esubcode = 9'h001; wb_ex_pc = 32'h200;
    tick();
    idle_inputs();
    checks++;
    if (dt_ex !== 1'b1 || dt_ertn !== 1'b0 || dt_ecode !== 6'h08 || dt_esubcode !== 9'h001 ||
        dt_ex_pc !== 32'h200) begin
      errors++;
      $display("FAIL exertn_exc: got ex=%b ertn=%b ecode=%h esub=%h pc=%h want 1 0 08 001 200",
               dt_ex, dt_ertn, dt_ecode, dt_esubcode, dt_ex_pc);
    end
    tick();
    checks++;
    if ({dt_valid, dt_ex, dt_ertn} !== 3'b000) begin
      errors++;
      $display("FAIL exertn_single: got %b want 000", {dt_valid, dt_ex, dt_ertn});
    end
    wb_ertn = 1; wb_ex_pc = 32'h300;
    tick();
    idle_inputs();
    checks++;
    if (dt_ertn !== 1'b1 || dt_ex !== 1'b0 || dt_ex_pc !== 32'h300) begin
      errors++;
      $display("FAIL ertn_only: got ertn=%b ex=%b pc=%h want 1 0 300", dt_ertn, dt_ex, dt_ex_pc);
    end
    tick();
  endtask

  task automatic test_halt_drain();
    int seen = 0;
    int cyc = 0;
    dt_ready = 0;
    for (int i = 0; i < 4; i++) begin
      commit(32'h400 + 32'(4 * i));
      tick();
    end
    idle_inputs();
    halt_req = 1;
    tick();
    halt_req = 0;
    while (halt_done !== 1'b1 && cyc < 40) begin
      dt_ready = cyc[0];
      #1;
      checks++;
      if (wb_ready !== 1'b0) begin
        errors++;
        $display("FAIL drain_ready_c%0d: got %b want 0", cyc, wb_ready);
      end
      if (dt_valid === 1'b1 && dt_ready === 1'b1) begin
        checks++;
        if (dt_pc !== 32'h400 + 32'(4 * seen)) begin
          errors++;
          $display("FAIL drain_order_%0d: got pc=%h want %h", seen, dt_pc,
                   32'h400 + 32'(4 * seen));
        end
        seen++;
      end
      tick();
      cyc++;
    end
    checks++;
    if (halt_done !== 1'b1 || seen != 4) begin
      errors++;
      $display("FAIL drain_done: got halt_done=%b emitted=%0d want 1 and 4", halt_done, seen);
    end
    dt_ready = 1;
    halt_req = 1;
    tick();
    halt_req = 0;
    tick();
    checks++;
    if (halt_done !== 1'b1 || wb_ready !== 1'b0 || dt_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_sticky: got hd=%b ready=%b v=%b want 1 0 0", halt_done, wb_ready,
               dt_valid);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    dt_ready = 0;
    for (int i = 0; i < 4; i++) begin
      commit(32'h500 + 32'(4 * i));
      tick();
    end
    idle_inputs();
    halt_req = 1;
    tick();
    halt_req = 0;
    reset = 1;
    tick();
    reset = 0;
    #1;
    checks++;
    if ({dt_valid, dt_ex, dt_ertn, halt_done} !== 4'b0 || dt_pc !== 0 || wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_drain: got v=%b ex=%b ertn=%b hd=%b pc=%h ready=%b want 0s, ready=1",
               dt_valid, dt_ex, dt_ertn, halt_done, dt_pc, wb_ready);
    end
    dt_ready = 1;
    repeat (4) begin
      tick();
      checks++;
      if (dt_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_stale: got v=%b pc=%h want no record", dt_valid, dt_pc);
      end
    end
    commit(32'h600);
    tick();
    idle_inputs();
    checks++;
    if (dt_valid !== 1'b1 || dt_pc !== 32'h600) begin
      errors++;
      $display("FAIL rst_fresh: got v=%b pc=%h want 1 600", dt_valid, dt_pc);
    end
    tick();
  endtask

  initial begin
    idle_inputs();
    dt_ready = 1;
    reset = 1;
    test_reset();
    test_commits();
    test_commit_exc();
    test_backpressure();
    test_ex_ertn();
    test_halt_drain();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
